// File: rtl/fa_bist_pkg.sv
// Shared types and sizes for the full-adder self-test checker.
package fa_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int VEC_W   = 3;
   localparam int ERR_W   = 4;
   localparam int NUM_VEC = 8;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

endpackage

// File: rtl/fa_golden.sv
// Combinational reference full adder: {ci,a,b} -> expected sum and carry-out.
module fa_golden
   import fa_bist_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             s,
   output logic             co
);

   assign s  = ^vec;
   assign co = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);

endmodule

// File: rtl/fa_bist_checker.sv
// Sweeps all eight {ci,a,b} vectors through a full adder and counts mismatches.
// Optional macro FA_BIST_FAIL_CAPTURE_EN builds the first-failing-vector capture.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// DRIVE  | current vector just applied to the adder
// SETTLE | settle down-counter running
// SAMPLE | compare adder outputs against golden model
// DONE   | one-cycle end-of-sweep pulse
module fa_bist_checker
   import fa_bist_pkg::*;
#(
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             drv_ci,
   output logic             drv_a,
   output logic             drv_b,
   input  logic             dut_s,
   input  logic             dut_co,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [VEC_W-1:0] first_fail_vec
);

   // The counter is loaded with SETTLE_CYC-1 so SETTLE spans exactly SETTLE_CYC cycles.
   localparam logic [3:0] SETTLE_LD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic [3:0]       settle_cnt;
   logic             exp_s;
   logic             exp_co;
   logic             mismatch;
   logic [ERR_W-1:0] err_nxt;

   fa_golden u_golden (
      .vec (vec),
      .s   (exp_s),
      .co  (exp_co)
   );

   assign mismatch = (dut_s != exp_s) || (dut_co != exp_co);
   assign err_nxt  = err_cnt + ERR_W'(mismatch);

   assign {drv_ci, drv_a, drv_b} = vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state   <= ST_DRIVE;
                  vec     <= '0;
                  err_cnt <= '0;
                  pass    <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (SETTLE_CYC == 0) begin
                  state <= ST_SAMPLE;
               end else begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SETTLE_LD;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 4'd0) state <= ST_SAMPLE;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            ST_SAMPLE: begin
               err_cnt <= err_nxt;
               if (vec == LAST_VEC) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end else begin
                  vec   <= vec + VEC_W'(1);
                  state <= ST_DRIVE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FA_BIST_FAIL_CAPTURE_EN
   logic             captured;
   logic [VEC_W-1:0] fail_vec_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         captured   <= 1'b0;
         fail_vec_q <= '0;
      end else if (state == ST_IDLE && start) begin
         captured   <= 1'b0;
         fail_vec_q <= '0;
      end else if (state == ST_SAMPLE && mismatch && !captured) begin
         captured   <= 1'b1;
         fail_vec_q <= vec;
      end
   end

   assign first_fail_vec = fail_vec_q;
`else
   assign first_fail_vec = '0;
`endif

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: two instances (settle 4 and 0) driving a fault-injectable adder model.
module tb_fa_bist_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start   [2];
   logic       ci_w    [2];
   logic       a_w     [2];
   logic       b_w     [2];
   logic       s_w     [2];
   logic       co_w    [2];
   logic       busy    [2];
   logic       done    [2];
   logic       pass    [2];
   logic [3:0] err_cnt [2];
   logic [2:0] ffv     [2];
   logic [2:0] drv_v   [2];
   logic [7:0] s_mask  [2];
   logic [7:0] co_mask [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic gold_s(input logic [2:0] v);
      return ($countones(v) % 2) == 1;
   endfunction

   function automatic logic gold_co(input logic [2:0] v);
      return $countones(v) >= 2;
   endfunction

   // Faulty adder: golden result flipped wherever the mask bit for that vector is set.
   assign drv_v[0] = {ci_w[0], a_w[0], b_w[0]};
   assign drv_v[1] = {ci_w[1], a_w[1], b_w[1]};
   assign s_w[0]   = gold_s(drv_v[0])  ^ s_mask[0][drv_v[0]];
   assign co_w[0]  = gold_co(drv_v[0]) ^ co_mask[0][drv_v[0]];
   assign s_w[1]   = gold_s(drv_v[1])  ^ s_mask[1][drv_v[1]];
   assign co_w[1]  = gold_co(drv_v[1]) ^ co_mask[1][drv_v[1]];

   fa_bist_checker #(.SETTLE_CYC(4)) dut4 (
      .clk(clk), .rst(rst), .start(start[0]),
      .drv_ci(ci_w[0]), .drv_a(a_w[0]), .drv_b(b_w[0]),
      .dut_s(s_w[0]), .dut_co(co_w[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_cnt(err_cnt[0]), .first_fail_vec(ffv[0])
   );

   fa_bist_checker #(.SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .start(start[1]),
      .drv_ci(ci_w[1]), .drv_a(a_w[1]), .drv_b(b_w[1]),
      .dut_s(s_w[1]), .dut_co(co_w[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_cnt(err_cnt[1]), .first_fail_vec(ffv[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_err(input logic [7:0] sm, input logic [7:0] cm);
      return $countones(sm | cm);
   endfunction

   function automatic int model_ffv(input logic [7:0] sm, input logic [7:0] cm);
`ifdef FA_BIST_FAIL_CAPTURE_EN
      logic [7:0] bad;
      bad = sm | cm;
      for (int i = 0; i < 8; i++) if (bad[i]) return i;
`endif
      return 0;
   endfunction

   // Runs one sweep on unit u and checks timing, vector sequence and results.
   task automatic sweep(input int u, input int settle, input logic [7:0] sm, input logic [7:0] cm,
                        input bit repulse, input int exp_err, input int exp_ffv, input bit exp_pass);
      int per, total, m, bad_drv, bad_busy, extra_busy, extra_done;
      per = settle + 2;
      total = 8 * per;
      s_mask[u] = sm;
      co_mask[u] = cm;
      @(negedge clk);
      start[u] = 1'b1;
      @(posedge clk); #1;
      start[u] = 1'b0;
      m = 0; bad_drv = 0; bad_busy = 0;
      while (done[u] !== 1'b1 && m < total + 20) begin
         if (int'(drv_v[u]) != m / per) bad_drv++;
         if (busy[u] !== 1'b1) bad_busy++;
         if (repulse && m == 10) start[u] = 1'b1;
         @(posedge clk); #1;
         start[u] = 1'b0;
         m++;
      end
      chk($sformatf("done_latency_u%0d", u), m, total);
      chk($sformatf("drv_sequence_u%0d", u), bad_drv, 0);
      chk($sformatf("busy_during_sweep_u%0d", u), bad_busy, 0);
      chk($sformatf("busy_in_done_u%0d", u), int'(busy[u]), 0);
      chk($sformatf("err_cnt_u%0d", u), int'(err_cnt[u]), exp_err);
      chk($sformatf("pass_u%0d", u), int'(pass[u]), int'(exp_pass));
      chk($sformatf("first_fail_vec_u%0d", u), int'(ffv[u]), exp_ffv);
      chk($sformatf("drv_hold_last_u%0d", u), int'(drv_v[u]), 7);
      if (repulse) start[u] = 1'b1;
      @(posedge clk); #1;
      start[u] = 1'b0;
      chk($sformatf("done_single_pulse_u%0d", u), int'(done[u]), 0);
      if (repulse) begin
         extra_busy = 0; extra_done = 0;
         for (int i = 0; i < 6; i++) begin
            if (busy[u] !== 1'b0) extra_busy++;
            if (done[u] !== 1'b0) extra_done++;
            @(posedge clk); #1;
         end
         chk("start_in_done_ignored_busy", extra_busy, 0);
         chk("start_in_done_ignored_done", extra_done, 0);
         chk("results_unchanged_err", int'(err_cnt[u]), exp_err);
         chk("results_unchanged_pass", int'(pass[u]), int'(exp_pass));
      end
   endtask

   typedef struct {
      logic [7:0] sm;
      logic [7:0] cm;
      int         settle;
      bit         repulse;
      int         exp_err;
      int         exp_ffv_cap;
      bit         exp_pass;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int u, e_ffv, m;
      logic [7:0] rs, rc;

      tbl[0] = '{8'h00, 8'h00, 4, 1'b0, 0, 0, 1'b1};
      tbl[1] = '{8'h00, 8'hE8, 4, 1'b0, 4, 3, 1'b0};
      tbl[2] = '{8'hFF, 8'h00, 4, 1'b0, 8, 0, 1'b0};
      tbl[3] = '{8'h00, 8'h00, 0, 1'b0, 0, 0, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 4, 1'b1, 0, 0, 1'b1};
      tbl[5] = '{8'h20, 8'h00, 0, 1'b0, 1, 5, 1'b0};

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         s_mask[i] = 8'h00;
         co_mask[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_drv_u%0d", i), int'(drv_v[i]), 0);
         chk($sformatf("reset_busy_u%0d", i), int'(busy[i]), 0);
         chk($sformatf("reset_done_u%0d", i), int'(done[i]), 0);
         chk($sformatf("reset_pass_u%0d", i), int'(pass[i]), 0);
         chk($sformatf("reset_err_u%0d", i), int'(err_cnt[i]), 0);
         chk($sformatf("reset_ffv_u%0d", i), int'(ffv[i]), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         u = (tbl[i].settle == 0) ? 1 : 0;
`ifdef FA_BIST_FAIL_CAPTURE_EN
         e_ffv = tbl[i].exp_ffv_cap;
`else
         e_ffv = 0;
`endif
         sweep(u, tbl[i].settle, tbl[i].sm, tbl[i].cm, tbl[i].repulse,
               tbl[i].exp_err, e_ffv, tbl[i].exp_pass);
      end

      for (int i = 0; i < 6; i++) begin
         u = $urandom_range(0, 1);
         rs = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(0, 255));
         if (i == 0) begin rs = 8'h00; rc = 8'h00; end
         sweep(u, (u == 0) ? 4 : 0, rs, rc, 1'b0, model_err(rs, rc), model_ffv(rs, rc),
               model_err(rs, rc) == 0);
      end

      // Reset while vector 5 is in SETTLE on the settle-4 unit.
      s_mask[0] = 8'hFF;
      co_mask[0] = 8'h00;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (m = 0; m < 32; m++) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_vec5", int'(drv_v[0]), 5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", int'(busy[0]), 0);
      chk("midrst_drv", int'(drv_v[0]), 0);
      chk("midrst_err", int'(err_cnt[0]), 0);
      chk("midrst_pass", int'(pass[0]), 0);
      chk("midrst_done", int'(done[0]), 0);
      sweep(0, 4, 8'h00, 8'h00, 1'b0, 0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
